// File: rtl/conv_pkg.sv
// Shared helpers for the convolution line family: clog2, derived datapath widths
// and a width-parametrised signed saturate.
package conv_pkg;

  localparam int SAT_CALC_W = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int oMultiplyW(input int ix, input int iw);
    return ix + iw;
  endfunction

  function automatic int oSumW(input int ix, input int iw, input int k);
    return oMultiplyW(ix, iw) + clog2(k);
  endfunction

  function automatic int oAdderW(input int ix, input int iw, input int k, input int ipsum);
    int s;
    s = oSumW(ix, iw, k);
    return ((s > ipsum) ? s : ipsum) + 1;
  endfunction

  // Clamp a sign-extended value into outW signed bits; the bounds themselves pass unclamped.
  function automatic logic signed [SAT_CALC_W-1:0] saturate(
    input  logic signed [SAT_CALC_W-1:0] v,
    input  int                           outW,
    output logic                         clamped
  );
    logic signed [SAT_CALC_W-1:0] maxV;
    logic signed [SAT_CALC_W-1:0] minV;
    maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (outW - 1));
    clamped = 1'b0;
    if (v > maxV) begin
      clamped = 1'b1;
      return maxV;
    end
    if (v < minV) begin
      clamped = 1'b1;
      return minV;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_sat.sv
// Final output stage of a convolution line: clamp (CONV_SAT_EN) or wrap the full
// precision sum to the output width, plus the sticky o_sat flag when clamping.
module conv_sat
  import conv_pkg::*;
#(
  parameter int I_W = 19,
  parameter int O_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic signed [I_W-1:0] i_sum,
  output logic                  o_valid,
  output logic signed [O_W-1:0] o_psum
`ifdef CONV_SAT_EN
  ,
  output logic                  o_sat
`endif
);

  logic                  valid_q;
  logic signed [O_W-1:0] psum_q;
  logic signed [O_W-1:0] psum_d;

`ifdef CONV_SAT_EN
  logic signed [SAT_CALC_W-1:0] satWide;
  logic                         clamped;
  logic                         sat_q;
  logic                         sat_d;

  always_comb begin
    clamped = 1'b0;
    satWide = saturate(SAT_CALC_W'(i_sum), O_W, clamped);
    psum_d  = O_W'(satWide);
    sat_d   = sat_q | (i_valid & clamped);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign o_sat = sat_q;
`else
  // Without clamping the result simply wraps in two's complement.
  always_comb begin
    psum_d = O_W'(i_sum);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      psum_q  <= '0;
    end else begin
      valid_q <= i_valid;
      if (i_valid) psum_q <= psum_d;
    end
  end

  assign o_valid = valid_q;
  assign o_psum  = psum_q;

endmodule

// File: rtl/convolution_line_k.sv
// K-tap weight-stationary 1-D convolution line with psum chaining, three pipeline
// stages. Define CONV_SAT_EN for output clamping and the sticky o_sat port.
module convolution_line_k
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int I_PSUM = 16,
  parameter int O_SAT  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_w_load,
  input  logic signed [I_W-1:0]    i_w,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [I_X-1:0]    i_x,
  input  logic signed [I_PSUM-1:0] i_psum,
  output logic                     o_valid,
  output logic signed [O_SAT-1:0]  o_psum
`ifdef CONV_SAT_EN
  ,
  output logic                     o_sat
`endif
);

  localparam int O_MULTIPLY = oMultiplyW(I_X, I_W);
  localparam int O_SUM      = oSumW(I_X, I_W, K);
  localparam int O_ADDER    = oAdderW(I_X, I_W, K, I_PSUM);
  localparam int FILL_W     = (clog2(K) < 1) ? 1 : clog2(K);

  logic signed [I_W-1:0]        w_q [K];
  // Only K-1 older samples are stored; the newest tap is fed straight from i_x.
  logic signed [I_X-1:0]        hist_q [K-1];
  logic signed [I_X-1:0]        histEff [K-1];
  logic [FILL_W-1:0]            fill_q;
  logic [FILL_W-1:0]            fillEff;
  logic                         stageValid;

  logic signed [O_MULTIPLY-1:0] prod_d [K];
  logic signed [O_MULTIPLY-1:0] prod_q [K];
  logic signed [I_PSUM-1:0]     psum0_q;
  logic                         valid0_q;

  logic signed [O_SUM-1:0]      sum_d;
  logic signed [O_SUM-1:0]      sum_q;
  logic signed [I_PSUM-1:0]     psum1_q;
  logic                         valid1_q;

  logic signed [O_ADDER-1:0]    total;

  always_comb begin
    for (int k = 0; k < K - 1; k++) histEff[k] = i_clear ? '0 : hist_q[k];
    fillEff    = i_clear ? '0 : fill_q;
    stageValid = i_valid && (fillEff == FILL_W'(K - 1));
    prod_d[0]  = O_MULTIPLY'(w_q[0]) * O_MULTIPLY'(i_x);
    for (int k = 1; k < K; k++) prod_d[k] = O_MULTIPLY'(w_q[k]) * O_MULTIPLY'(histEff[k-1]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < K; k++) w_q[k] <= '0;
      for (int k = 0; k < K - 1; k++) hist_q[k] <= '0;
      fill_q <= '0;
    end else begin
      if (i_w_load) begin
        for (int k = 0; k < K - 1; k++) w_q[k] <= w_q[k+1];
        w_q[K-1] <= i_w;
      end
      if (i_valid) begin
        hist_q[0] <= i_x;
        for (int k = 1; k < K - 1; k++) hist_q[k] <= histEff[k-1];
        fill_q <= (fillEff == FILL_W'(K - 1)) ? fillEff : fillEff + 1'b1;
      end else if (i_clear) begin
        for (int k = 0; k < K - 1; k++) hist_q[k] <= '0;
        fill_q <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid0_q <= 1'b0;
      psum0_q  <= '0;
      for (int k = 0; k < K; k++) prod_q[k] <= '0;
    end else begin
      valid0_q <= stageValid;
      if (stageValid) begin
        psum0_q <= i_psum;
        for (int k = 0; k < K; k++) prod_q[k] <= prod_d[k];
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < K; k++) sum_d = sum_d + O_SUM'(prod_q[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid1_q <= 1'b0;
      sum_q    <= '0;
      psum1_q  <= '0;
    end else begin
      valid1_q <= valid0_q;
      if (valid0_q) begin
        sum_q   <= sum_d;
        psum1_q <= psum0_q;
      end
    end
  end

  assign total = O_ADDER'(sum_q) + O_ADDER'(psum1_q);

  conv_sat #(
    .I_W(O_ADDER),
    .O_W(O_SAT)
  ) u_sat (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(valid1_q),
    .i_sum  (total),
    .o_valid(o_valid),
    .o_psum (o_psum)
`ifdef CONV_SAT_EN
    ,
    .o_sat  (o_sat)
`endif
  );

endmodule

// File: tb/tb_convolution_line_k.sv
// Self-checking bench for convolution_line_k: directed scenarios plus random traffic,
// all compared every cycle against a history-list reference model.
module tb_convolution_line_k;

  localparam int K      = 3;
  localparam int I_X    = 8;
  localparam int I_W    = 8;
  localparam int I_PSUM = 16;
  localparam int O_SAT  = 16;

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_w_load = 1'b0;
  logic signed [I_W-1:0]    i_w = '0;
  logic                     i_clear = 1'b0;
  logic                     i_valid = 1'b0;
  logic signed [I_X-1:0]    i_x = '0;
  logic signed [I_PSUM-1:0] i_psum = '0;
  logic                     o_valid;
  logic signed [O_SAT-1:0]  o_psum;
`ifdef CONV_SAT_EN
  logic                     o_sat;
`endif

  convolution_line_k #(
    .K(K), .I_X(I_X), .I_W(I_W), .I_PSUM(I_PSUM), .O_SAT(O_SAT)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_w_load(i_w_load),
    .i_w     (i_w),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .i_x     (i_x),
    .i_psum  (i_psum),
    .o_valid (o_valid),
    .o_psum  (o_psum)
`ifdef CONV_SAT_EN
    ,
    .o_sat   (o_sat)
`endif
  );

  initial forever #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;

  longint wM [K];
  longint histM [$];
  bit     pipeV [3];
  longint pipeY [3];
  bit     pipeC [3];
  bit     satM = 1'b0;
  bit     started = 1'b0;

  typedef struct {
    int     edgeNo;
    longint val;
  } outRec_t;
  outRec_t gotQ [$];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint fitOut(input longint y, output bit clamped);
    logic signed [O_SAT-1:0] t;
    longint maxV;
    longint minV;
    maxV = (longint'(1) << (O_SAT - 1)) - 1;
    minV = -(longint'(1) << (O_SAT - 1));
    clamped = 1'b0;
`ifdef CONV_SAT_EN
    if (y > maxV) begin
      clamped = 1'b1;
      return maxV;
    end
    if (y < minV) begin
      clamped = 1'b1;
      return minV;
    end
    return y;
`else
    t = y[O_SAT-1:0];
    if (maxV < minV) clamped = 1'b1;
    return longint'(t);
`endif
  endfunction

  // The line's result for a sample is psum + sum over taps of weight times the sample k back.
  task automatic modelStep();
    longint acc;
    bit     newV;
    longint newY;
    bit     newC;
    edgeCnt++;
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        pipeV[i] = 1'b0;
        pipeY[i] = 0;
        pipeC[i] = 1'b0;
      end
      for (int k = 0; k < K; k++) wM[k] = 0;
      histM.delete();
      satM    = 1'b0;
      started = 1'b1;
      return;
    end
    newV = 1'b0;
    newY = 0;
    newC = 1'b0;
    if (i_clear) histM.delete();
    if (i_valid) begin
      acc = longint'(i_psum) + wM[0] * longint'(i_x);
      for (int k = 1; k < K; k++)
        if (k - 1 < histM.size()) acc += wM[k] * histM[k-1];
      newV = (histM.size() == K - 1);
      newY = fitOut(acc, newC);
      histM.push_front(longint'(i_x));
      if (histM.size() > K - 1) void'(histM.pop_back());
    end
    if (i_w_load) begin
      for (int k = 0; k < K - 1; k++) wM[k] = wM[k+1];
      wM[K-1] = longint'(i_w);
    end
    pipeV[2] = pipeV[1]; pipeY[2] = pipeY[1]; pipeC[2] = pipeC[1];
    pipeV[1] = pipeV[0]; pipeY[1] = pipeY[0]; pipeC[1] = pipeC[0];
    pipeV[0] = newV & newC | newV;
    pipeY[0] = newY;
    pipeC[0] = newV & newC;
    if (pipeV[2] && pipeC[2]) satM = 1'b1;
  endtask

  initial forever begin
    @(posedge i_clk);
    modelStep();
  end

  initial forever begin
    @(negedge i_clk);
    if (started) begin
      checkOutput("o_valid", longint'(o_valid), longint'(pipeV[2]));
      if (pipeV[2]) checkOutput("o_psum", longint'(o_psum), pipeY[2]);
`ifdef CONV_SAT_EN
      checkOutput("o_sat", longint'(o_sat), longint'(satM));
`endif
    end
    if (o_valid === 1'b1) gotQ.push_back('{edgeCnt, longint'(o_psum)});
  end

  task automatic applyStimulus(input bit rst, input bit load, input int w, input bit clr,
                               input bit vld, input int x, input int psum, output int edgeNo);
    i_rst    = rst;
    i_w_load = load;
    i_w      = I_W'(w);
    i_clear  = clr;
    i_valid  = vld;
    i_x      = I_X'(x);
    i_psum   = I_PSUM'(psum);
    @(posedge i_clk);
    @(negedge i_clk);
    edgeNo = edgeCnt;
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, e);
  endtask

  task automatic loadW(input int w);
    int e;
    applyStimulus(0, 1, w, 0, 0, 0, 0, e);
  endtask

  task automatic sample(input bit clr, input int x, input int psum, output int e);
    applyStimulus(0, 0, 0, clr, 1, x, psum, e);
  endtask

  function automatic longint gotVal(input int i);
    return (i < gotQ.size()) ? gotQ[i].val : -999999;
  endfunction

  function automatic int gotEdge(input int i);
    return (i < gotQ.size()) ? gotQ[i].edgeNo : -1;
  endfunction

  initial begin
    int e, eA, eB;
    int r;
    bit rst, ld, clr, vld;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, e);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, e);
    checkOutput("reset o_valid", longint'(o_valid), 0);
    checkOutput("reset o_psum", longint'(o_psum), 0);
`ifdef CONV_SAT_EN
    checkOutput("reset o_sat", longint'(o_sat), 0);
`endif
    idle(2);

    // Basic line: weights 1,2,3 against 10,20,30,40.
    loadW(1); loadW(2); loadW(3);
    gotQ.delete();
    sample(0, 10, 0, e); sample(0, 20, 0, e); sample(0, 30, 0, eA); sample(0, 40, 0, e);
    idle(5);
    checkOutput("line count", gotQ.size(), 2);
    checkOutput("line first", gotVal(0), 100);
    checkOutput("line second", gotVal(1), 160);
    checkOutput("line latency", gotEdge(0), eA + 2);

    gotQ.delete();
    sample(1, 10, 0, e); sample(0, 20, 0, e); sample(0, 30, -50, e);
    idle(5);
    checkOutput("chain count", gotQ.size(), 1);
    checkOutput("chain value", gotVal(0), 50);

    gotQ.delete();
    sample(1, 10, 0, e); idle(1); sample(0, 20, 0, e); idle(2);
    sample(0, 30, 0, eA); idle(1); sample(0, 40, 0, eB);
    idle(5);
    checkOutput("bubble count", gotQ.size(), 2);
    checkOutput("bubble first", gotVal(0), 100);
    checkOutput("bubble second", gotVal(1), 160);
    checkOutput("bubble gap", gotEdge(1) - gotEdge(0), eB - eA);

    gotQ.delete();
    sample(1, 7, 0, e); sample(0, 1, 0, e); sample(0, 2, 0, eA);
    idle(5);
    checkOutput("clear count", gotQ.size(), 1);
    checkOutput("clear value", gotVal(0), 25);
    checkOutput("clear latency", gotEdge(0), eA + 2);

    loadW(100); loadW(100); loadW(100);
    gotQ.delete();
    sample(1, 100, 0, e); sample(0, 100, 0, e); sample(0, 100, 5000, e);
    idle(5);
`ifdef CONV_SAT_EN
    checkOutput("sat high", gotVal(0), 32767);
    checkOutput("sat flag", longint'(o_sat), 1);
`else
    checkOutput("wrap high", gotVal(0), -30536);
`endif

    loadW(127); loadW(127); loadW(127);
    gotQ.delete();
    sample(1, -128, 0, e); sample(0, -128, 0, e); sample(0, -128, 0, e);
    idle(5);
`ifdef CONV_SAT_EN
    checkOutput("sat low", gotVal(0), -32768);
`else
    checkOutput("wrap low", gotVal(0), 16768);
`endif

    // Weight load coinciding with a sample: old weights for it, shifted ones after.
    loadW(1); loadW(2); loadW(3);
    gotQ.delete();
    sample(1, 10, 0, e); sample(0, 20, 0, e); sample(0, 30, 0, e);
    applyStimulus(0, 1, 5, 0, 1, 40, 0, e);
    sample(0, 50, 0, e);
    idle(5);
    checkOutput("load-stream count", gotQ.size(), 3);
    checkOutput("load-stream old w", gotVal(1), 160);
    checkOutput("load-stream new w", gotVal(2), 370);

    gotQ.delete();
    sample(0, 60, 0, e); sample(0, 70, 0, e);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, e);
    checkOutput("midrst o_valid", longint'(o_valid), 0);
    checkOutput("midrst o_psum", longint'(o_psum), 0);
    idle(4);
    checkOutput("midrst drained", gotQ.size(), 0);
    loadW(1); loadW(2); loadW(3);
    sample(0, 1, 0, e); sample(0, 2, 0, e); sample(0, 3, 0, eA);
    idle(5);
    checkOutput("post-rst count", gotQ.size(), 1);
    checkOutput("post-rst value", gotVal(0), 10);
    checkOutput("post-rst latency", gotEdge(0), eA + 2);

    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 99));
      rst = (r < 2);
      ld  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 19) == 0);
      vld = ($urandom_range(0, 9) < 7);
      applyStimulus(rst, ld, int'($urandom_range(0, 255)) - 128, clr, vld,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 65535)) - 32768, e);
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
